// File: rtl/pw_trigger_pkg.sv
// Shared types and default sizing for the trigger pulse-train sequencer.
package pw_trigger_pkg;

  localparam int unsigned DEF_DELAY_WIDTH = 20;
  localparam int unsigned DEF_WIDTH_WIDTH = 17;
  localparam int unsigned DEF_NUM_PULSES  = 4;
  localparam int unsigned SEQ_COUNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_PULSE,
    ST_DONE
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pw_trigger_timer.sv
// Phase timer: restartable up-counter flagging when it equals the current phase target.
module pw_trigger_timer #(
  parameter int unsigned pCNT_WIDTH = 20
) (
  input  logic                  trigger_clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  start_one,
  input  logic [pCNT_WIDTH-1:0] target,
  output logic                  hit_c
);

  logic [pCNT_WIDTH-1:0] cnt_q, cnt_d;

  // A restart loads 1 when the phase's first cycle must count toward the target.
  always_comb begin
    cnt_d = cnt_q + pCNT_WIDTH'(1);
    if (clear) cnt_d = pCNT_WIDTH'(start_one);
  end

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign hit_c = (cnt_q == target);

endmodule

// File: rtl/pw_trigger_sched.sv
// Trigger sequencer: arm, match-edge start, programmable delay/width pulse train.
// Optional auto re-arm and sequence counter under PW_TRIG_AUTO_REARM_EN.
module pw_trigger_sched
  import pw_trigger_pkg::*;
#(
  parameter int unsigned pTRIGGER_DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter int unsigned pTRIGGER_WIDTH_WIDTH = DEF_WIDTH_WIDTH,
  parameter int unsigned pNUM_PULSES          = DEF_NUM_PULSES,
  localparam int unsigned pIDX_WIDTH          = $clog2(pNUM_PULSES)
) (
  input  logic                                          trigger_clk,
  input  logic                                          reset_n,
  input  logic                                          I_arm,
  input  logic                                          I_disarm,
  input  logic [pIDX_WIDTH-1:0]                         I_num_pulses,
  input  logic [pNUM_PULSES*pTRIGGER_DELAY_WIDTH-1:0]   I_delays,
  input  logic [pNUM_PULSES*pTRIGGER_WIDTH_WIDTH-1:0]   I_widths,
  input  logic                                          I_match,
`ifdef PW_TRIG_AUTO_REARM_EN
  input  logic                                          I_auto_rearm,
  output logic [SEQ_COUNT_WIDTH-1:0]                    O_seq_count,
`endif
  output logic                                          O_trigger,
  output logic                                          O_armed,
  output logic                                          O_busy,
  output logic                                          O_done,
  output logic [pIDX_WIDTH-1:0]                         O_pulse_idx
);

  localparam int unsigned CNT_W     = max_u(pTRIGGER_DELAY_WIDTH, pTRIGGER_WIDTH_WIDTH);
  localparam int unsigned DLY_BUS_W = pNUM_PULSES * pTRIGGER_DELAY_WIDTH;
  localparam int unsigned WID_BUS_W = pNUM_PULSES * pTRIGGER_WIDTH_WIDTH;

  state_e                        state_q, state_d;
  logic                          match_q, match_evt_c;
  logic [pIDX_WIDTH-1:0]         num_q, num_d, idx_q, idx_d;
  logic [DLY_BUS_W-1:0]          delays_q, delays_d;
  logic [WID_BUS_W-1:0]          widths_q, widths_d;
  logic                          trigger_q, trigger_d, armed_q, armed_d;
  logic                          busy_q, busy_d, done_q, done_d;
  logic                          tmr_clear_c, tmr_start_c, tmr_hit_c;
  logic [CNT_W-1:0]              tmr_target_c;
  logic [pTRIGGER_DELAY_WIDTH-1:0] delay_cur_c, delay0_c;
  logic [pTRIGGER_WIDTH_WIDTH-1:0] width_cur_c;
`ifdef PW_TRIG_AUTO_REARM_EN
  logic [SEQ_COUNT_WIDTH-1:0]    seq_cnt_q, seq_cnt_d;
`endif

  assign match_evt_c = I_match & ~match_q;
  assign delay0_c    = delays_q[pTRIGGER_DELAY_WIDTH-1:0];
  assign delay_cur_c = delays_q[32'(idx_q)*pTRIGGER_DELAY_WIDTH +: pTRIGGER_DELAY_WIDTH];
  assign width_cur_c = widths_q[32'(idx_q)*pTRIGGER_WIDTH_WIDTH +: pTRIGGER_WIDTH_WIDTH];

  pw_trigger_timer #(.pCNT_WIDTH(CNT_W)) u_timer (
    .trigger_clk (trigger_clk),
    .reset_n     (reset_n),
    .clear       (tmr_clear_c),
    .start_one   (tmr_start_c),
    .target      (tmr_target_c),
    .hit_c       (tmr_hit_c)
  );

  // Next-state, shadow capture and registered output decode.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    num_d        = num_q;
    delays_d     = delays_q;
    widths_d     = widths_q;
    tmr_target_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (I_arm && !I_disarm) begin
          num_d    = I_num_pulses;
          delays_d = I_delays;
          widths_d = I_widths;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (I_disarm)         state_d = ST_IDLE;
        else if (match_evt_c) state_d = (delay0_c == '0) ? ST_PULSE : ST_DELAY;
      end
      ST_DELAY: begin
        tmr_target_c = CNT_W'(delay_cur_c);
        if (I_disarm)       state_d = ST_IDLE;
        else if (tmr_hit_c) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        tmr_target_c = (width_cur_c == '0) ? CNT_W'(1) : CNT_W'(width_cur_c);
        if (I_disarm) begin
          state_d = ST_IDLE;
        end else if (tmr_hit_c) begin
          if (idx_q == num_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + pIDX_WIDTH'(1);
            state_d = ST_DELAY;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef PW_TRIG_AUTO_REARM_EN
        if (I_auto_rearm && !I_disarm) state_d = ST_ARMED;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_ARMED && state_q != ST_ARMED) idx_d = '0;

    // First delay counts from 1 (the match cycle is cycle 0); inter-pulse gaps count from 0.
    tmr_clear_c = (state_d != state_q) || !(state_q inside {ST_DELAY, ST_PULSE});
    tmr_start_c = (state_d == ST_PULSE) || (state_q == ST_ARMED);

    trigger_d = (state_d == ST_PULSE);
    armed_d   = (state_d == ST_ARMED);
    busy_d    = (state_d == ST_DELAY) || (state_d == ST_PULSE);
    done_d    = (state_d == ST_DONE);
  end

`ifdef PW_TRIG_AUTO_REARM_EN
  always_comb begin
    seq_cnt_d = seq_cnt_q;
    if (state_q == ST_IDLE && I_arm && !I_disarm) seq_cnt_d = '0;
    else if (state_q == ST_DONE && seq_cnt_q != '1) seq_cnt_d = seq_cnt_q + SEQ_COUNT_WIDTH'(1);
  end

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) seq_cnt_q <= '0;
    else          seq_cnt_q <= seq_cnt_d;
  end

  assign O_seq_count = seq_cnt_q;
`endif

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      match_q   <= 1'b0;
      idx_q     <= '0;
      num_q     <= '0;
      delays_q  <= '0;
      widths_q  <= '0;
      trigger_q <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= I_match;
      idx_q     <= idx_d;
      num_q     <= num_d;
      delays_q  <= delays_d;
      widths_q  <= widths_d;
      trigger_q <= trigger_d;
      armed_q   <= armed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign O_trigger   = trigger_q;
  assign O_armed     = armed_q;
  assign O_busy      = busy_q;
  assign O_done      = done_q;
  assign O_pulse_idx = idx_q;

endmodule

// File: tb/tb_pw_trigger_sched.sv
// Scoreboard bench for pw_trigger_sched: expected pulses/done pushed at match time, checked at output.
module tb_pw_trigger_sched;

  localparam int unsigned DW = 20;
  localparam int unsigned WW = 17;
  localparam int unsigned NP = 4;
  localparam int unsigned IW = 2;

  typedef struct { int rise; int width; int idx; } exp_pulse_t;
  typedef struct { int cyc;  int idx; }             exp_done_t;

  logic              trigger_clk;
  logic              reset_n;
  logic              I_arm, I_disarm, I_match;
  logic [IW-1:0]     I_num_pulses;
  logic [NP*DW-1:0]  I_delays;
  logic [NP*WW-1:0]  I_widths;
  logic              O_trigger, O_armed, O_busy, O_done;
  logic [IW-1:0]     O_pulse_idx;
`ifdef PW_TRIG_AUTO_REARM_EN
  logic              I_auto_rearm;
  logic [15:0]       O_seq_count;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  bit         mon_en = 1'b1;
  int         cfg_num;
  int         cfg_d [NP];
  int         cfg_w [NP];
  exp_pulse_t exp_pulses [$];
  exp_done_t  exp_dones  [$];

  pw_trigger_sched #(
    .pTRIGGER_DELAY_WIDTH (DW),
    .pTRIGGER_WIDTH_WIDTH (WW),
    .pNUM_PULSES          (NP)
  ) dut (
    .trigger_clk  (trigger_clk),
    .reset_n      (reset_n),
    .I_arm        (I_arm),
    .I_disarm     (I_disarm),
    .I_num_pulses (I_num_pulses),
    .I_delays     (I_delays),
    .I_widths     (I_widths),
    .I_match      (I_match),
`ifdef PW_TRIG_AUTO_REARM_EN
    .I_auto_rearm (I_auto_rearm),
    .O_seq_count  (O_seq_count),
`endif
    .O_trigger    (O_trigger),
    .O_armed      (O_armed),
    .O_busy       (O_busy),
    .O_done       (O_done),
    .O_pulse_idx  (O_pulse_idx)
  );

  initial begin
    trigger_clk = 1'b0;
    forever #5 trigger_clk = ~trigger_clk;
  end

  initial forever begin
    @(posedge trigger_clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge trigger_clk);
  endtask

  // Expected pulse train for a match first seen in cycle t.
  task automatic push_seq(input int t);
    int rise;
    int last;
    int w;
    rise = t + 1 + cfg_d[0];
    last = rise;
    for (int k = 0; k <= cfg_num; k++) begin
      w = (cfg_w[k] == 0) ? 1 : cfg_w[k];
      exp_pulses.push_back('{rise: rise, width: w, idx: k});
      last = rise + w - 1;
      if (k < cfg_num) rise = last + cfg_d[k+1] + 2;
    end
    exp_dones.push_back('{cyc: last + 1, idx: cfg_num});
  endtask

  task automatic load_cfg();
    I_num_pulses = IW'(cfg_num);
    for (int k = 0; k < NP; k++) begin
      I_delays[k*DW +: DW] = DW'(cfg_d[k]);
      I_widths[k*WW +: WW] = WW'(cfg_w[k]);
    end
  endtask

  task automatic scramble();
    I_num_pulses = IW'($urandom);
    for (int k = 0; k < NP; k++) begin
      I_delays[k*DW +: DW] = DW'($urandom_range(0, 3));
      I_widths[k*WW +: WW] = WW'($urandom_range(0, 3));
    end
  endtask

  task automatic do_arm();
    load_cfg();
    I_arm = 1'b1;
    cyc_wait(1);
    I_arm = 1'b0;
    scramble();
  endtask

  task automatic do_match(input int len, input bit expect_seq);
    if (expect_seq) push_seq(cyc);
    I_match = 1'b1;
    cyc_wait(len);
    I_match = 1'b0;
  endtask

  task automatic pulse_disarm();
    I_disarm = 1'b1;
    cyc_wait(1);
    I_disarm = 1'b0;
  endtask

  // Output monitor: measures each trigger pulse and each done strobe.
  initial begin
    bit         trig_prev;
    int         rise_cyc;
    int         rise_idx;
    exp_pulse_t p;
    exp_done_t  d;
    trig_prev = 1'b0;
    rise_cyc  = 0;
    rise_idx  = 0;
    forever begin
      @(negedge trigger_clk);
      if (mon_en) begin
        if (O_trigger && !trig_prev) begin
          rise_cyc = cyc;
          rise_idx = 32'(O_pulse_idx);
          check_eq("busy_in_pulse", 32'(O_busy), 1);
        end
        if (!O_trigger && trig_prev) begin
          if (exp_pulses.size() == 0) begin
            check_eq("unexpected_pulse", 1, 0);
          end else begin
            p = exp_pulses.pop_front();
            check_eq("pulse_rise", rise_cyc, p.rise);
            check_eq("pulse_width", cyc - rise_cyc, p.width);
            check_eq("pulse_idx", rise_idx, p.idx);
          end
        end
        if (O_done) begin
          if (exp_dones.size() == 0) begin
            check_eq("unexpected_done", 1, 0);
          end else begin
            d = exp_dones.pop_front();
            check_eq("done_cycle", cyc, d.cyc);
            check_eq("done_idx", 32'(O_pulse_idx), d.idx);
            check_eq("done_trig_low", 32'(O_trigger), 0);
          end
        end
      end
      trig_prev = O_trigger;
    end
  end

  initial begin
    reset_n  = 1'b0;
    I_arm    = 1'b0;
    I_disarm = 1'b0;
    I_match  = 1'b0;
    I_num_pulses = '0;
    I_delays = '0;
    I_widths = '0;
`ifdef PW_TRIG_AUTO_REARM_EN
    I_auto_rearm = 1'b0;
`endif
    #23;
    check_eq("rst_trigger", 32'(O_trigger), 0);
    check_eq("rst_armed", 32'(O_armed), 0);
    check_eq("rst_busy", 32'(O_busy), 0);
    check_eq("rst_done", 32'(O_done), 0);
    check_eq("rst_idx", 32'(O_pulse_idx), 0);
    @(negedge trigger_clk);
    reset_n = 1'b1;
    cyc_wait(2);

    // Single pulse; a second arm with a different config while armed is ignored.
    cfg_num = 0; cfg_d = '{5, 9, 9, 9}; cfg_w = '{3, 9, 9, 9};
    do_arm();
    check_eq("armed_after_arm", 32'(O_armed), 1);
    I_arm = 1'b1;
    cyc_wait(1);
    I_arm = 1'b0;
    cyc_wait(1);
    do_match(4, 1'b1);
    check_eq("single_delay_busy", 32'(O_busy), 1);
    check_eq("single_delay_trig", 32'(O_trigger), 0);
    cyc_wait(15);
    check_eq("single_idle_armed", 32'(O_armed), 0);
    check_eq("single_idle_busy", 32'(O_busy), 0);
    check_eq("single_pulses_left", exp_pulses.size(), 0);

    // Three-pulse train with zero delay and zero width entries.
    cfg_num = 2; cfg_d = '{0, 2, 4, 9}; cfg_w = '{1, 0, 2, 9};
    do_arm();
    do_match(1, 1'b1);
    cyc_wait(20);
    check_eq("train_pulses_left", exp_pulses.size(), 0);
    check_eq("train_dones_left", exp_dones.size(), 0);

    // Index clears on entry to ARMED; disarm from ARMED returns to IDLE.
    cfg_num = 0; cfg_d = '{1, 0, 0, 0}; cfg_w = '{2, 0, 0, 0};
    do_arm();
    check_eq("idx_clear_on_arm", 32'(O_pulse_idx), 0);
    pulse_disarm();
    check_eq("disarm_from_armed", 32'(O_armed), 0);

    // Matches while idle and a match in the arming cycle start nothing.
    do_match(2, 1'b0);
    cyc_wait(2);
    do_match(3, 1'b0);
    cyc_wait(5);
    check_eq("idle_match_trig", 32'(O_trigger), 0);
    load_cfg();
    I_arm = 1'b1;
    I_match = 1'b1;
    cyc_wait(1);
    I_arm = 1'b0;
    cyc_wait(3);
    I_match = 1'b0;
    cyc_wait(5);
    check_eq("arm_cycle_match_armed", 32'(O_armed), 1);
    check_eq("arm_cycle_match_busy", 32'(O_busy), 0);
    do_match(1, 1'b1);
    cyc_wait(8);

    // A fresh match edge during a pulse neither retriggers nor extends it.
    cfg_num = 0; cfg_d = '{2, 0, 0, 0}; cfg_w = '{6, 0, 0, 0};
    do_arm();
    do_match(1, 1'b1);
    cyc_wait(3);
    do_match(2, 1'b0);
    cyc_wait(15);
    check_eq("inseq_pulses_left", exp_pulses.size(), 0);

    // Disarm during DELAY: no pulse, no done.
    cfg_num = 0; cfg_d = '{10, 0, 0, 0}; cfg_w = '{2, 0, 0, 0};
    do_arm();
    do_match(1, 1'b0);
    cyc_wait(2);
    pulse_disarm();
    check_eq("dis_delay_busy", 32'(O_busy), 0);
    check_eq("dis_delay_trig", 32'(O_trigger), 0);
    check_eq("dis_delay_armed", 32'(O_armed), 0);
    cyc_wait(20);

    // Disarm during PULSE truncates it after three high cycles, no done.
    cfg_num = 0; cfg_d = '{1, 0, 0, 0}; cfg_w = '{8, 0, 0, 0};
    do_arm();
    begin
      int t;
      t = cyc;
      exp_pulses.push_back('{rise: t + 2, width: 3, idx: 0});
    end
    do_match(1, 1'b0);
    cyc_wait(3);
    check_eq("dis_pulse_high", 32'(O_trigger), 1);
    pulse_disarm();
    check_eq("dis_pulse_trig", 32'(O_trigger), 0);
    check_eq("dis_pulse_busy", 32'(O_busy), 0);
    cyc_wait(15);

    // Simultaneous arm and disarm never arms, in IDLE or in ARMED.
    I_arm = 1'b1; I_disarm = 1'b1;
    cyc_wait(1);
    I_arm = 1'b0; I_disarm = 1'b0;
    check_eq("arm_dis_idle", 32'(O_armed), 0);
    do_match(1, 1'b0);
    cyc_wait(10);
    do_arm();
    I_arm = 1'b1; I_disarm = 1'b1;
    cyc_wait(1);
    I_arm = 1'b0; I_disarm = 1'b0;
    check_eq("arm_dis_armed", 32'(O_armed), 0);
    do_match(1, 1'b0);
    cyc_wait(10);

    // Asynchronous reset in the middle of a pulse.
    mon_en = 1'b0;
    cfg_num = 0; cfg_d = '{1, 0, 0, 0}; cfg_w = '{10, 0, 0, 0};
    do_arm();
    do_match(1, 1'b0);
    begin
      int n;
      n = 0;
      while (!O_trigger && n < 10) begin
        cyc_wait(1);
        n++;
      end
    end
    check_eq("rst_pulse_seen", 32'(O_trigger), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_trig", 32'(O_trigger), 0);
    check_eq("async_rst_busy", 32'(O_busy), 0);
    @(negedge trigger_clk);
    reset_n = 1'b1;
    cyc_wait(1);
    check_eq("post_rst_armed", 32'(O_armed), 0);
    check_eq("post_rst_busy", 32'(O_busy), 0);
    check_eq("post_rst_trig", 32'(O_trigger), 0);
    mon_en = 1'b1;
    cyc_wait(2);

`ifdef PW_TRIG_AUTO_REARM_EN
    // Auto re-arm: three matches give three sequences and a count of three.
    I_auto_rearm = 1'b1;
    cfg_num = 0; cfg_d = '{1, 0, 0, 0}; cfg_w = '{1, 0, 0, 0};
    do_arm();
    for (int i = 0; i < 3; i++) begin
      do_match(1, 1'b1);
      cyc_wait(8);
      check_eq("rearm_armed", 32'(O_armed), 1);
    end
    check_eq("seq_count", 32'(O_seq_count), 3);
    I_auto_rearm = 1'b0;
    pulse_disarm();
    do_arm();
    check_eq("seq_count_clr", 32'(O_seq_count), 0);
    pulse_disarm();
    cyc_wait(2);
`endif

    check_eq("final_pulses_left", exp_pulses.size(), 0);
    check_eq("final_dones_left", exp_dones.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pw_trigger_sched.md
Name: pw_trigger_sched

Overview:
- Sequencer in front of the trigger output path.
- Arms on host command and converts the pattern-match level into a single-cycle event, so only one sequence starts per match.
- Plays out a programmable train of up to pNUM_PULSES trigger pulses, each with its own delay and width, then reports done.
- Sits between the register block and the trigger output pin, all in the trigger_clk domain.

Parameters:
- pTRIGGER_DELAY_WIDTH, 20: bit width of each per-pulse delay.
- pTRIGGER_WIDTH_WIDTH, 17: bit width of each per-pulse width.
- pNUM_PULSES, 4: maximum pulses per sequence; must be a power of 2, ≥2.
- pIDX_WIDTH, $clog2(pNUM_PULSES): localparam, pulse index width.

Ports:
- trigger_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- I_arm  in  1  single-cycle arm request.
- I_disarm  in  1  single-cycle abort/disarm.
- I_num_pulses  in  pIDX_WIDTH  pulse count minus 1.
- I_delays  in  pNUM_PULSES*pTRIGGER_DELAY_WIDTH  delay k at slice k.
- I_widths  in  pNUM_PULSES*pTRIGGER_WIDTH_WIDTH  width k at slice k.
- I_match  in  1  match level from pattern matcher; may stay high for several cycles.
- O_trigger  out  1  registered trigger output.
- O_armed  out  1  high in ARMED.
- O_busy  out  1  high in DELAY or PULSE.
- O_done  out  1  one-cycle pulse when the last pulse ends.
- O_pulse_idx  out  pIDX_WIDTH  index of the current or next pulse.

Behaviour:
- Reset (async on reset_n low): state IDLE, all outputs 0, match_q 0, shadow registers 0.
- Edge detect: match_q registers I_match each cycle; match_evt = I_match & ~match_q.
- IDLE:
  - I_arm & ~I_disarm: latch I_num_pulses, I_delays, I_widths into shadow registers; go ARMED.
  - Later changes on those inputs have no effect until the next arm.
- ARMED:
  - match_evt at cycle t: go DELAY, counter = 0, idx = 0.
  - I_disarm: go IDLE.
  - I_arm: ignored, no re-latch.
- DELAY:
  - Counter increments each cycle.
  - Pulse 0: O_trigger rises at t+1+D0. With D0 = 0, high in cycle t+1.
  - Pulse k > 0: O_trigger low for exactly Dk+1 cycles after the previous pulse falls. Pulses never merge.
- PULSE:
  - O_trigger high exactly max(Wk,1) cycles; W = 0 is treated as 1.
  - At the end: if idx == shadow num_pulses, go DONE; else idx+1 and go DELAY.
- DONE: one cycle. O_done = 1, O_trigger = 0, then go IDLE.
- Counter width: max(pTRIGGER_DELAY_WIDTH, pTRIGGER_WIDTH_WIDTH). Comparisons are equality against the shadow value. No wrap is possible because the counter clears on every state change.
- match_evt outside ARMED is dropped. No retrigger or extension during a sequence.
- I_disarm in DELAY or PULSE:
  - Next cycle: state IDLE, O_trigger 0. O_done is not pulsed.
  - Simultaneous I_arm and I_disarm: disarm wins in every state.
- Match edge in the same cycle as I_arm in IDLE: ignored, since arming takes effect next cycle.
- Output decode:
  - O_armed = (state == ARMED).
  - O_busy = DELAY | PULSE.
  - O_pulse_idx holds its value in DONE and clears on entry to ARMED.

Optional Feature:
- Macro PW_TRIG_AUTO_REARM_EN.
- When defined:
  - Adds input I_auto_rearm (1 bit) and output O_seq_count (16 bits).
  - DONE goes to ARMED instead of IDLE when I_auto_rearm = 1; shadow registers are kept.
  - O_seq_count increments on each DONE, saturates at 0xFFFF, and clears on I_arm from IDLE and on reset.
- When undefined: ports are absent and DONE always goes to IDLE.

Decomposition:
- Package pw_trigger_pkg:
  - State enum: IDLE, ARMED, DELAY, PULSE, DONE.
  - Default width constants (20, 17) and default pNUM_PULSES.
- Sub-module pw_trigger_timer:
  - Loadable up-counter with a terminal flag.
  - Inputs: clear, target; output: hit.
  - Used for both delay and width phases.
- FSM, shadow registers and edge detect stay in the top level.

Test Plan:
- Single pulse: arm, num=0, D0=5, W0=3; I_match high for 4 cycles from t → O_trigger high at t+6..t+8, O_done at t+9, exactly one pulse.
- Train: num=2, D={0,2,4}, W={1,0,2} → pulses of 1,1,2 cycles, low gaps of 3 and 5 cycles, O_pulse_idx 0→1→2, one O_done.
- Unarmed and in-sequence matches: matches while IDLE, and a second match during a pulse → no added or extended pulse; O_trigger length unchanged.
- Disarm mid-DELAY and simultaneous arm+disarm → IDLE next cycle, O_trigger 0, no O_done; simultaneous case never arms.
- Async reset asserted mid-PULSE away from a clock edge → O_trigger 0 immediately, state IDLE after release.
- With PW_TRIG_AUTO_REARM_EN and I_auto_rearm=1: three matches → three sequences, O_seq_count=3, O_armed high between them.
